// File: rtl/max_reduce_pkg.sv
// rtl/max_reduce_pkg.sv - shared types and defaults for the signed max stream reducer
// Optional argmax tracking is enabled by defining MAX_REDUCE_ARGMAX_EN.
package max_reduce_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

   localparam int DEF_WIDTH     = 16;
   localparam int DEF_LEN_W     = 8;
   localparam int DEF_IMPL_TYPE = 1;

endpackage

// File: rtl/max_reduce_step.sv
// rtl/max_reduce_step.sv - one signed compare+select step of the running maximum
// IMPL_TYPE 0 uses a native signed compare, otherwise an offset-binary unsigned compare.
module max_reduce_step
   import max_reduce_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int IMPL_TYPE = DEF_IMPL_TYPE
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic [WIDTH-1:0] i_acc,
   output logic             o_gt,
   output logic [WIDTH-1:0] o_sel
);

   generate
      if (IMPL_TYPE == 0) begin : g_signed_cmp
         assign o_gt = $signed(i_data) > $signed(i_acc);
      end else begin : g_offset_cmp
         // Flipping the sign bit maps two's complement onto an order-preserving unsigned range.
         logic [WIDTH-1:0] w_data_ob;
         logic [WIDTH-1:0] w_acc_ob;
         assign w_data_ob = {~i_data[WIDTH-1], i_data[WIDTH-2:0]};
         assign w_acc_ob  = {~i_acc[WIDTH-1],  i_acc[WIDTH-2:0]};
         assign o_gt      = w_data_ob > w_acc_ob;
      end
   endgenerate

   assign o_sel = o_gt ? i_data : i_acc;

endmodule

// File: rtl/max_int_stream_reduce.sv
// rtl/max_int_stream_reduce.sv - framed stream to per-frame signed maximum, valid/ready on both sides
// Define MAX_REDUCE_ARGMAX_EN to add the winning-beat index register and out_idx port.
module max_int_stream_reduce
   import max_reduce_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int LEN_W     = DEF_LEN_W,
   parameter int IMPL_TYPE = DEF_IMPL_TYPE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_max,
   output logic [LEN_W:0]   out_count,
`ifdef MAX_REDUCE_ARGMAX_EN
   output logic [LEN_W-1:0] out_idx,
`endif
   output logic             out_trunc
);

   localparam logic [1:0]   ST_IDLE  = IDLE;
   localparam logic [1:0]   ST_ACCUM = ACCUM;
   localparam logic [1:0]   ST_HOLD  = HOLD;
   localparam logic [LEN_W:0] MAX_CNT = {1'b1, {LEN_W{1'b0}}};

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_acc;
   logic [LEN_W:0]   r_cnt;
   logic             r_trunc;
   logic             w_accept;
   logic             w_gt;
   logic [WIDTH-1:0] w_sel;
   logic [LEN_W:0]   w_cnt_inc;
   logic             w_full;

   assign w_accept  = in_valid && r_in_ready;
   assign w_cnt_inc = r_cnt + (LEN_W+1)'(1);
   assign w_full    = (w_cnt_inc == MAX_CNT);

   max_reduce_step #(
      .WIDTH     (WIDTH),
      .IMPL_TYPE (IMPL_TYPE)
   ) u_step (
      .i_data (in_data),
      .i_acc  (r_acc),
      .o_gt   (w_gt),
      .o_sel  (w_sel)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept) w_state_nxt = in_last ? ST_HOLD : ST_ACCUM;
         ST_ACCUM: if (w_accept && (in_last || w_full)) w_state_nxt = ST_HOLD;
         ST_HOLD:  if (out_ready) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Handshake flags are registered from the next state so in_ready stays low through reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_trunc     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt != ST_HOLD);
         r_out_valid <= (w_state_nxt == ST_HOLD);
         if (w_accept) begin
            if (r_state == ST_IDLE) begin
               r_acc   <= in_data;
               r_cnt   <= (LEN_W+1)'(1);
               r_trunc <= 1'b0;
            end else begin
               if (w_gt) r_acc <= w_sel;
               r_cnt   <= w_cnt_inc;
               r_trunc <= w_full && !in_last;
            end
         end
      end
   end

`ifdef MAX_REDUCE_ARGMAX_EN
   logic [LEN_W-1:0] r_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
      end else if (w_accept) begin
         if (r_state == ST_IDLE) r_idx <= '0;
         else if (w_gt)          r_idx <= r_cnt[LEN_W-1:0];
      end
   end

   assign out_idx = r_idx;
`endif

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_max   = r_acc;
   assign out_count = r_cnt;
   assign out_trunc = r_trunc;

endmodule

// File: tb/tb_max_int_stream_reduce.sv
// tb/tb_max_int_stream_reduce.sv - directed and randomized checks of max_int_stream_reduce
// Define MAX_REDUCE_ARGMAX_EN to also check out_idx.
module tb_max_int_stream_reduce;

   localparam int WIDTH = 16;
   localparam int LW    = 2;
   localparam int FMAX  = 1 << LW;
   localparam int NB    = 300;

   typedef struct {
      int mx;
      int cnt;
      int trunc;
      int idx;
   } res_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_max;
   logic [LW:0]      out_count;
   logic             out_trunc;
`ifdef MAX_REDUCE_ARGMAX_EN
   logic [LW-1:0]    out_idx;
`endif

   int n_chk = 0;
   int n_err = 0;

   int   bd[NB];
   bit   bl[NB];
   res_t exp_q[$];

   always #5 clk = ~clk;

   max_int_stream_reduce #(
      .WIDTH     (WIDTH),
      .LEN_W     (LW),
      .IMPL_TYPE (1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_max   (out_max),
      .out_count (out_count),
`ifdef MAX_REDUCE_ARGMAX_EN
      .out_idx   (out_idx),
`endif
      .out_trunc (out_trunc)
   );

   task automatic check_eq(input string tag, input int got, input int want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, want);
      end
   endtask

   // Called at a negedge; returns at the negedge after the beat is taken.
   task automatic send_beat(input int v, input bit last);
      int n = 0;
      in_valid = 1'b1;
      in_data  = v[WIDTH-1:0];
      in_last  = last;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check_eq("in_ready_timeout", int'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic expect_result(input string tag, input int emax, input int ecnt,
                                input int etrunc, input int eidx);
      int n = 0;
      out_ready = 1'b1;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_valid"}, int'(out_valid), 1);
      check_eq({tag, "_max"},   int'($signed(out_max)), emax);
      check_eq({tag, "_count"}, int'(out_count), ecnt);
      check_eq({tag, "_trunc"}, int'(out_trunc), etrunc);
`ifdef MAX_REDUCE_ARGMAX_EN
      check_eq({tag, "_idx"},   int'(out_idx), eidx);
`endif
      @(negedge clk);
      out_ready = 1'b0;
      check_eq({tag, "_vdrop"}, int'(out_valid), 0);
   endtask

   // Reference: split stream into frames at in_last or FMAX beats; earliest strict max wins.
   function automatic void build_expected();
      int cur[$];
      res_t r;
      exp_q.delete();
      for (int i = 0; i < NB; i++) begin
         cur.push_back(bd[i]);
         if (bl[i] || cur.size() == FMAX) begin
            r.mx = cur[0];
            r.idx = 0;
            for (int j = 1; j < cur.size(); j++)
               if (cur[j] > r.mx) begin
                  r.mx  = cur[j];
                  r.idx = j;
               end
            r.cnt   = cur.size();
            r.trunc = (cur.size() == FMAX && !bl[i]) ? 1 : 0;
            exp_q.push_back(r);
            cur.delete();
         end
      end
   endfunction

   function automatic int rand_val();
      int sel = $urandom_range(0, 3);
      int raw = $urandom;
      if (sel == 0)      return ($urandom_range(0, 1) == 1) ? 32767 : -32768;
      else if (sel == 1) return $urandom_range(0, 6) - 3;
      else               return int'($signed(raw[15:0]));
   endfunction

   initial begin
      int snap;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_in_ready",  int'(in_ready), 0);
      check_eq("rst_out_valid", int'(out_valid), 0);
      check_eq("rst_out_max",   int'(out_max), 0);
      check_eq("rst_out_count", int'(out_count), 0);
      check_eq("rst_out_trunc", int'(out_trunc), 0);
`ifdef MAX_REDUCE_ARGMAX_EN
      check_eq("rst_out_idx",   int'(out_idx), 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_in_ready", int'(in_ready), 1);

      // basic frame
      send_beat(3, 0); send_beat(-7, 0); send_beat(12, 0); send_beat(5, 1);
      check_eq("t1_latency", int'(out_valid), 1);
      check_eq("t1_hold_in_ready", int'(in_ready), 0);
      expect_result("t1", 12, 4, 0, 2);

      // full-range extremes and all-negative
      send_beat(-32768, 0); send_beat(32767, 0); send_beat(-1, 1);
      expect_result("t2a", 32767, 3, 0, 1);
      send_beat(-5, 0); send_beat(-2, 0); send_beat(-9, 1);
      expect_result("t2b", -2, 3, 0, 1);

      // ties keep earliest
      send_beat(4, 0); send_beat(9, 0); send_beat(9, 0); send_beat(1, 1);
      expect_result("t3", 9, 4, 0, 1);

      // single beat, consumer back-pressure
      send_beat(-32768, 1);
      for (int k = 0; k < 5; k++) begin
         check_eq("t4_hold_valid", int'(out_valid), 1);
         check_eq("t4_hold_in_ready", int'(in_ready), 0);
         check_eq("t4_hold_max", int'($signed(out_max)), -32768);
         check_eq("t4_hold_count", int'(out_count), 1);
         @(negedge clk);
      end
      expect_result("t4", -32768, 1, 0, 0);

      // truncation at 2**LW beats
      send_beat(2, 0); send_beat(8, 0); send_beat(-1, 0); send_beat(6, 0);
      check_eq("t5_trunc_in_ready", int'(in_ready), 0);
      expect_result("t5", 8, 4, 1, 1);
      send_beat(-4, 0);
      check_eq("t5_next_trunc_clr", int'(out_trunc), 0);
      check_eq("t5_next_count", int'(out_count), 1);
`ifdef MAX_REDUCE_ARGMAX_EN
      check_eq("t5_next_idx_clr", int'(out_idx), 0);
`endif
      send_beat(-3, 1);
      expect_result("t5b", -3, 2, 0, 1);

      // reset mid-frame
      send_beat(100, 0); send_beat(200, 0);
      rst_n = 1'b0;
      #1;
      check_eq("t6_rst_valid", int'(out_valid), 0);
      check_eq("t6_rst_in_ready", int'(in_ready), 0);
      check_eq("t6_rst_count", int'(out_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_beat(7, 1);
      expect_result("t6", 7, 1, 0, 0);

      // randomized stream with random back-pressure on both sides
      for (int i = 0; i < NB; i++) begin
         bd[i] = rand_val();
         bl[i] = ($urandom_range(0, 3) == 0) || (i == NB - 1);
      end
      build_expected();
      snap = 0;
      fork
         begin : drv
            int i = 0;
            int guard = 0;
            while (i < NB && guard < 20000) begin
               in_valid = ($urandom_range(0, 3) != 0);
               in_data  = bd[i][WIDTH-1:0];
               in_last  = bl[i];
               if (in_valid && in_ready) i++;
               @(negedge clk);
               guard++;
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
         end
         begin : mon
            int guard = 0;
            res_t e;
            while (snap < exp_q.size() && guard < 20000) begin
               out_ready = ($urandom_range(0, 2) != 0);
               if (out_valid && out_ready) begin
                  e = exp_q[snap];
                  check_eq("rnd_max",   int'($signed(out_max)), e.mx);
                  check_eq("rnd_count", int'(out_count), e.cnt);
                  check_eq("rnd_trunc", int'(out_trunc), e.trunc);
`ifdef MAX_REDUCE_ARGMAX_EN
                  check_eq("rnd_idx",   int'(out_idx), e.idx);
`endif
                  snap++;
               end
               @(negedge clk);
               guard++;
            end
            out_ready = 1'b0;
         end
      join
      check_eq("rnd_results", snap, exp_q.size());
      repeat (2) @(negedge clk);
      check_eq("rnd_idle_valid", int'(out_valid), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
